receiver_buffer2: RTL and testbench
===================================

Name: receiver_buffer2

Overview:
- Receive-side counterpart of the core's byte-serial sender path.
- Takes bytes from the UART receiver and packs every 4 bytes into a 32-bit word, MSB-first: the first byte lands in [31:24].
- Queues completed words in a 2**NUM-entry FIFO that the core pops.
- The UART cannot be back-pressured, so a word that arrives when there is no room is dropped and reported through a sticky flag.

Parameters:
- NUM, 5, log2 of FIFO depth (depth = 32 words).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- rx_data  input  8  received byte; valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte.
- resync  input  1  discards any partially assembled word; FIFO contents are untouched.
- pop  input  1  core consumes the head word; ignored when valid=0.
- clear_overflow  input  1  clears the overflow flag.
- data  output  32  head FIFO word, show-ahead; holds its last value when empty.
- valid  output  1  FIFO not empty.
- count  output  NUM+1  number of words in the FIFO, 0..2**NUM.
- overflow  output  1  sticky: at least one completed word was dropped.
- partial  output  1  byte assembler holds 1..3 bytes.

Behaviour:
- Reset (reset=0, asynchronous):
  - head=0, tail=0, count=0, byte_idx=0, assembly register=0.
  - Outputs: data=0, valid=0, overflow=0, partial=0.
  - FIFO memory contents need not be cleared.
  - Reset mid-word or mid-pop loses all state; there is no partial recovery.
- Assembler state byte_idx in 0..3:
  - On rx_valid, byte_idx=k writes rx_data into bits [31-8k -: 8] and increments byte_idx.
  - On rx_valid with byte_idx=3, the word {b0,b1,b2,rx_data} is pushed and byte_idx wraps to 0.
- Push latency:
  - Fourth rx_valid in cycle t → valid=1, data=word, count incremented in cycle t+1.
  - No gap is required between bytes; rx_valid may be high on consecutive cycles.
- resync:
  - Sets byte_idx=0 on the next edge.
  - If resync and rx_valid are high in the same cycle, resync wins and the byte is discarded.
- Pop:
  - With pop=1 and valid=1, head advances on the edge.
  - data shows the next entry in the following cycle, or valid drops if the FIFO becomes empty.
  - pop with valid=0 has no effect; count must not underflow.
- Full (count=2**NUM):
  - A completing 4th byte with no simultaneous pop drops the word and sets overflow=1.
  - byte_idx still wraps to 0.
  - A completing 4th byte with a simultaneous pop is accepted; count stays 2**NUM.
- Simultaneous push and pop while not full: head and tail both advance, count unchanged.
  - When count=1, data shows the new word next cycle and valid stays 1.
- overflow:
  - Cleared by clear_overflow.
  - If a drop and clear_overflow occur in the same cycle, the set wins (overflow=1).
- Pointers and count:
  - head/tail are NUM bits and wrap modulo 2**NUM.
  - Full/empty is decided by count, not by pointer equality alone.
- partial = (byte_idx != 0).
- No combinational path from inputs to outputs; data is read from registered state.

Decomposition:
- Package uart_buf_pkg:
  - BYTES_PER_WORD=4.
  - WORD_W=32.
  - Typedef word_t (logic [31:0]).
  - Typedef byte_idx_t (logic [1:0]).
  - The same package is also imported by the transmit side.
- Sub-module word_fifo (parameterised by NUM and the WORD_W width):
  - Ports: push/pop/din/dout/count/full/empty.
  - Owns pointers, count and the memory array.
- receiver_buffer2 itself holds the assembler, the drop/overflow logic and the resync logic.

Test Plan:
- Reset, then bytes 0xDE,0xAD,0xBE,0xEF on 4 consecutive cycles → one cycle after the last byte: valid=1, data=0xDEADBEEF, count=1, partial=0. Then pop → valid=0, count=0.
- Bytes 0x11,0x22, then resync, then 0x01,0x02,0x03,0x04 → data=0x01020304, count=1; no word containing 0x11 ever appears.
- 32 words 0x00000000..0x0000001F without popping → count=32. A 33rd word 0xFFFFFFFF gives overflow=1, count=32. Pops then return 0x00..0x1F in order, wrapping the pointers.
- Full FIFO, 4th byte of 0xCAFEF00D in the same cycle as pop → overflow stays 0, count=32. The last entry read is 0xCAFEF00D.
- count=1, pop in the same cycle as a completed word 0x12345678 → count stays 1, valid stays 1, data=0x12345678 next cycle.
- Pull reset low asynchronously between edges mid-word (byte_idx=2) with count=5 → count=0, valid=0, partial=0 immediately. After release, the next 4 bytes form a clean word.

Source files
------------

// File: rtl/uart_buf_pkg.sv
// ---------------------------------------------------------------------------
// uart_buf_pkg
// Definitions that the UART receive and transmit byte/word paths share.
// It holds the word geometry, the word and byte-index types, and the index
// of the last byte in a word.
// ---------------------------------------------------------------------------
package uart_buf_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [1:0]        byte_idx_t;

    // Index of the byte that completes a word.
    localparam byte_idx_t LAST_BYTE_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/receiver_buffer2_word_fifo.sv
// ---------------------------------------------------------------------------
// word_fifo
// Synchronous show-ahead FIFO with 2**NUM entries of W bits each.
// The head word is held in a register. The output therefore has no
// combinational path from the inputs, and it keeps the last word after the
// FIFO drains.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   push   in   write din at the tail. It is accepted when not full, or when
//               full and a pop happens in the same cycle.
//   pop    in   advance the head. It is ignored when empty.
//   din    in   W-bit word to write
//   dout   out  registered head word
//   count  out  number of stored words, 0..2**NUM
//   full   out  count == 2**NUM
//   empty  out  count == 0
// ---------------------------------------------------------------------------
module word_fifo #(
    parameter int NUM = 5,
    parameter int W   = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic           pop,
    input  logic [W-1:0]   din,
    output logic [W-1:0]   dout,
    output logic [NUM:0]   count,
    output logic           full,
    output logic           empty
);

    localparam int           DEPTH      = 1 << NUM;
    localparam logic [NUM:0] FULL_COUNT = (NUM+1)'(DEPTH);

    logic [W-1:0]   r_mem [DEPTH];
    logic [NUM-1:0] r_head;
    logic [NUM-1:0] r_tail;
    logic [NUM:0]   r_count;
    logic [W-1:0]   r_dout;

    logic           w_doPop;
    logic           w_doPush;
    logic [NUM-1:0] w_nextHead;
    logic [NUM:0]   w_nextCount;
    logic [W-1:0]   w_doutNext;

    assign full  = (r_count == FULL_COUNT);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_dout;

    // A full FIFO can accept a push only when the pop frees a slot in the
    // same cycle.
    assign w_doPop     = pop && !empty;
    assign w_doPush    = push && (!full || w_doPop);
    assign w_nextHead  = r_head + NUM'(w_doPop);
    assign w_nextCount = r_count + (NUM+1)'(w_doPush) - (NUM+1)'(w_doPop);

    // The head slot is written in this same cycle exactly when the tail meets
    // the next head. That happens on a push into an empty FIFO, or on a
    // push+pop at count 1. In both cases the new word bypasses the memory.
    // When the FIFO drains, the old head word stays on the output.
    always_comb begin
        w_doutNext = r_dout;
        if (w_doPush && (r_tail == w_nextHead))
            w_doutNext = din;
        else if (w_nextCount != '0)
            w_doutNext = r_mem[w_nextHead];
    end

    // The storage array has no reset because the contents are qualified
    // by count.
    always_ff @(posedge clk) begin
        if (w_doPush)
            r_mem[r_tail] <= din;
    end

    // Pointers wrap naturally modulo the depth. Full and empty come from
    // count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_dout  <= '0;
        end else begin
            r_head  <= w_nextHead;
            r_count <= w_nextCount;
            r_dout  <= w_doutNext;
            if (w_doPush)
                r_tail <= r_tail + NUM'(1);
        end
    end

endmodule

// File: rtl/receiver_buffer2.sv
// ---------------------------------------------------------------------------
// receiver_buffer2
// Receive-side byte-to-word packer. Bytes from the UART are packed MSB-first
// into 32-bit words, so the first byte lands in [31:24]. Completed words are
// queued in a 2**NUM-entry FIFO that the core pops. The UART cannot be
// stalled, so a word that completes while the FIFO is full and not being
// popped is dropped, and the sticky overflow flag records the drop.
//
// Ports:
//   CLK             in   clock, rising edge
//   reset           in   asynchronous active-low reset
//   rx_data[7:0]    in   received byte, qualified by rx_valid
//   rx_valid        in   one-cycle strobe per byte
//   resync          in   abandon the partially assembled word. It wins over
//                        rx_valid.
//   pop             in   consume the head word. It is ignored when empty.
//   clear_overflow  in   clear the sticky overflow flag
//   data[31:0]      out  head word, show-ahead, held when empty
//   valid           out  FIFO not empty
//   count[NUM:0]    out  number of queued words
//   overflow        out  sticky: a completed word was dropped
//   partial         out  the assembler holds 1..3 bytes
// ---------------------------------------------------------------------------
module receiver_buffer2
    import uart_buf_pkg::*;
#(
    parameter int NUM = 5
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         resync,
    input  logic         pop,
    input  logic         clear_overflow,
    output word_t        data,
    output logic         valid,
    output logic [NUM:0] count,
    output logic         overflow,
    output logic         partial
);

    // Only the first three bytes need storage. The fourth byte goes
    // straight into the pushed word.
    logic [WORD_W-9:0] r_asm;
    byte_idx_t         r_byteIdx;
    logic              r_overflow;

    logic  w_byteAccept;
    logic  w_wordDone;
    logic  w_drop;
    word_t w_word;
    logic  w_full;
    logic  w_empty;

    assign w_byteAccept = rx_valid && !resync;
    assign w_wordDone   = w_byteAccept && (r_byteIdx == LAST_BYTE_IDX);
    assign w_word       = {r_asm, rx_data};

    // Drop only when full and no pop frees a slot. The pop is effective
    // whenever the FIFO is full, because full implies not empty.
    assign w_drop = w_wordDone && w_full && !(pop && !w_empty);

    word_fifo #(
        .NUM (NUM),
        .W   (WORD_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (reset),
        .push  (w_wordDone),
        .pop   (pop),
        .din   (w_word),
        .dout  (data),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign valid    = !w_empty;
    assign overflow = r_overflow;
    assign partial  = (r_byteIdx != '0);

    // Byte assembler. resync drops any byte in the same cycle. The index
    // wraps to 0 after the fourth byte, whether or not the word was queued.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_asm     <= '0;
            r_byteIdx <= '0;
        end else if (resync) begin
            r_byteIdx <= '0;
        end else if (rx_valid) begin
            case (r_byteIdx)
                2'd0:    r_asm[23:16] <= rx_data;
                2'd1:    r_asm[15:8]  <= rx_data;
                2'd2:    r_asm[7:0]   <= rx_data;
                default: ;
            endcase
            r_byteIdx <= r_byteIdx + byte_idx_t'(1);
        end
    end

    // Sticky overflow. A drop in the same cycle as a clear leaves it set.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
        else if (clear_overflow)
            r_overflow <= 1'b0;
    end

endmodule

// File: tb/tb_receiver_buffer2.sv
// ---------------------------------------------------------------------------
// tb_receiver_buffer2
// Directed scenarios followed by a randomized run. Expected values come from
// constants and from a queue-based model of the byte stream and the word
// FIFO.
// ---------------------------------------------------------------------------
module tb_receiver_buffer2;
    import uart_buf_pkg::*;

    logic       CLK = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       resync;
    logic       pop;
    logic       clear_overflow;
    word_t      data;
    logic       valid;
    logic [5:0] count;
    logic       overflow;
    logic       partial;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model: pending bytes, queued words, sticky flag, last head.
    logic [7:0] mBuf[$];
    word_t      mQ[$];
    logic       mOvf;
    word_t      mData;

    receiver_buffer2 #(.NUM(5)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .resync         (resync),
        .pop            (pop),
        .clear_overflow (clear_overflow),
        .data           (data),
        .valid          (valid),
        .count          (count),
        .overflow       (overflow),
        .partial        (partial)
    );

    always #5 CLK = ~CLK;

    // Clear the model to its reset state.
    task automatic modelReset();
        mBuf.delete();
        mQ.delete();
        mOvf  = 1'b0;
        mData = '0;
    endtask

    // Drive one cycle of inputs, clock it, and advance the model.
    // Outputs are stable 1 time unit after the edge.
    task automatic step(input logic rv, input logic [7:0] rd, input logic rs,
                        input logic pp, input logic clr);
        logic  popEff;
        logic  doneW;
        logic  wasFull;
        logic  dropped;
        word_t w;
        rx_valid       = rv;
        rx_data        = rd;
        resync         = rs;
        pop            = pp;
        clear_overflow = clr;
        @(posedge CLK);
        popEff  = pp && (mQ.size() != 0);
        wasFull = (mQ.size() == 32);
        doneW   = 1'b0;
        dropped = 1'b0;
        w       = '0;
        if (rs) begin
            mBuf.delete();
        end else if (rv) begin
            mBuf.push_back(rd);
            if (mBuf.size() == 4) begin
                w = {mBuf[0], mBuf[1], mBuf[2], mBuf[3]};
                doneW = 1'b1;
                mBuf.delete();
            end
        end
        if (popEff) void'(mQ.pop_front());
        if (doneW) begin
            if (!wasFull || popEff) mQ.push_back(w);
            else dropped = 1'b1;
        end
        if (dropped) mOvf = 1'b1;
        else if (clr) mOvf = 1'b0;
        if (mQ.size() != 0) mData = mQ[0];
        #1;
        rx_valid = 1'b0; resync = 1'b0; pop = 1'b0; clear_overflow = 1'b0;
    endtask

    task automatic pushWord(input word_t w);
        step(1'b1, w[31:24], 1'b0, 1'b0, 1'b0);
        step(1'b1, w[23:16], 1'b0, 1'b0, 1'b0);
        step(1'b1, w[15:8],  1'b0, 1'b0, 1'b0);
        step(1'b1, w[7:0],   1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_valid = 1'b0; rx_data = '0; resync = 1'b0;
        pop = 1'b0; clear_overflow = 1'b0;
        modelReset();
        #12;
        nChecks++; if (data !== 32'h0) $display("[TB] FAIL reset_data: got %h want 0", data); else nPass++;
        nChecks++; if (valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", valid); else nPass++;
        nChecks++; if (count !== 6'd0) $display("[TB] FAIL reset_count: got %0d want 0", count); else nPass++;
        nChecks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b want 0", overflow); else nPass++;
        nChecks++; if (partial !== 1'b0) $display("[TB] FAIL reset_partial: got %b want 0", partial); else nPass++;
        reset = 1'b1;
        #4;
    endtask

    task automatic test_basic();
        step(1'b1, 8'hDE, 1'b0, 1'b0, 1'b0);
        nChecks++; if (partial !== 1'b1) $display("[TB] FAIL basic_partial1: got %b want 1", partial); else nPass++;
        step(1'b1, 8'hAD, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hBE, 1'b0, 1'b0, 1'b0);
        nChecks++; if (valid !== 1'b0) $display("[TB] FAIL basic_early_valid: got %b want 0", valid); else nPass++;
        step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b0);
        nChecks++; if (valid !== 1'b1) $display("[TB] FAIL basic_valid: got %b want 1", valid); else nPass++;
        nChecks++; if (data !== 32'hDEADBEEF) $display("[TB] FAIL basic_data: got %h want deadbeef", data); else nPass++;
        nChecks++; if (count !== 6'd1) $display("[TB] FAIL basic_count: got %0d want 1", count); else nPass++;
        nChecks++; if (partial !== 1'b0) $display("[TB] FAIL basic_partial0: got %b want 0", partial); else nPass++;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        nChecks++; if (valid !== 1'b0) $display("[TB] FAIL basic_pop_valid: got %b want 0", valid); else nPass++;
        nChecks++; if (count !== 6'd0) $display("[TB] FAIL basic_pop_count: got %0d want 0", count); else nPass++;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        nChecks++; if (count !== 6'd0) $display("[TB] FAIL basic_underflow: got %0d want 0", count); else nPass++;
        nChecks++; if (data !== 32'hDEADBEEF) $display("[TB] FAIL basic_hold: got %h want deadbeef", data); else nPass++;
    endtask

    task automatic test_resync();
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        nChecks++; if (partial !== 1'b0) $display("[TB] FAIL resync_partial: got %b want 0", partial); else nPass++;
        pushWord(32'h01020304);
        nChecks++; if (data !== 32'h01020304) $display("[TB] FAIL resync_data: got %h want 01020304", data); else nPass++;
        nChecks++; if (count !== 6'd1) $display("[TB] FAIL resync_count: got %0d want 1", count); else nPass++;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 32; i++) pushWord(word_t'(i));
        nChecks++; if (count !== 6'd32) $display("[TB] FAIL fill_count: got %0d want 32", count); else nPass++;
        nChecks++; if (overflow !== 1'b0) $display("[TB] FAIL fill_no_ovf: got %b want 0", overflow); else nPass++;
        pushWord(32'hFFFFFFFF);
        nChecks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_set: got %b want 1", overflow); else nPass++;
        nChecks++; if (count !== 6'd32) $display("[TB] FAIL ovf_count: got %0d want 32", count); else nPass++;
        for (int i = 0; i < 32; i++) begin
            nChecks++; if (data !== word_t'(i)) $display("[TB] FAIL drain_data[%0d]: got %h want %h", i, data, word_t'(i)); else nPass++;
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        nChecks++; if (valid !== 1'b0) $display("[TB] FAIL drain_valid: got %b want 0", valid); else nPass++;
        nChecks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b want 1", overflow); else nPass++;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        nChecks++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_clear: got %b want 0", overflow); else nPass++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 32; i++) pushWord(32'h100 + word_t'(i));
        step(1'b1, 8'hCA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h0D, 1'b0, 1'b1, 1'b0);
        nChecks++; if (overflow !== 1'b0) $display("[TB] FAIL fullpp_ovf: got %b want 0", overflow); else nPass++;
        nChecks++; if (count !== 6'd32) $display("[TB] FAIL fullpp_count: got %0d want 32", count); else nPass++;
        for (int i = 1; i < 32; i++) begin
            nChecks++; if (data !== 32'h100 + word_t'(i)) $display("[TB] FAIL fullpp_data[%0d]: got %h want %h", i, data, 32'h100 + word_t'(i)); else nPass++;
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        nChecks++; if (data !== 32'hCAFEF00D) $display("[TB] FAIL fullpp_last: got %h want cafef00d", data); else nPass++;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        nChecks++; if (valid !== 1'b0) $display("[TB] FAIL fullpp_empty: got %b want 0", valid); else nPass++;
    endtask

    task automatic test_back_to_back();
        pushWord(32'hA5A5A5A5);
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h56, 1'b0, 1'b0, 1'b0);
        nChecks++; if (data !== 32'hA5A5A5A5) $display("[TB] FAIL b2b_pre: got %h want a5a5a5a5", data); else nPass++;
        step(1'b1, 8'h78, 1'b0, 1'b1, 1'b0);
        nChecks++; if (count !== 6'd1) $display("[TB] FAIL b2b_count: got %0d want 1", count); else nPass++;
        nChecks++; if (valid !== 1'b1) $display("[TB] FAIL b2b_valid: got %b want 1", valid); else nPass++;
        nChecks++; if (data !== 32'h12345678) $display("[TB] FAIL b2b_data: got %h want 12345678", data); else nPass++;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) pushWord(32'h5000 + word_t'(i));
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
        nChecks++; if (count !== 6'd5) $display("[TB] FAIL arst_pre_count: got %0d want 5", count); else nPass++;
        #3;
        reset = 1'b0;
        modelReset();
        #1;
        nChecks++; if (count !== 6'd0) $display("[TB] FAIL arst_count: got %0d want 0", count); else nPass++;
        nChecks++; if (valid !== 1'b0) $display("[TB] FAIL arst_valid: got %b want 0", valid); else nPass++;
        nChecks++; if (partial !== 1'b0) $display("[TB] FAIL arst_partial: got %b want 0", partial); else nPass++;
        nChecks++; if (data !== 32'h0) $display("[TB] FAIL arst_data: got %h want 0", data); else nPass++;
        #2;
        reset = 1'b1;
        pushWord(32'h0BADF00D);
        nChecks++; if (data !== 32'h0BADF00D) $display("[TB] FAIL arst_after_data: got %h want 0badf00d", data); else nPass++;
        nChecks++; if (count !== 6'd1) $display("[TB] FAIL arst_after_count: got %0d want 1", count); else nPass++;
    endtask

    task automatic test_random();
        logic rv, rs, pp, clr;
        for (int c = 0; c < 3000; c++) begin
            rv  = ($urandom_range(99) < 60);
            rs  = ($urandom_range(99) < 3);
            pp  = (c < 1200) ? ($urandom_range(99) < 5) : ($urandom_range(99) < 35);
            clr = ($urandom_range(99) < 2);
            step(rv, 8'($urandom), rs, pp, clr);
            nChecks++; if (valid !== (mQ.size() != 0)) $display("[TB] FAIL rnd_valid@%0d: got %b want %b", c, valid, mQ.size() != 0); else nPass++;
            nChecks++; if (count !== 6'(mQ.size())) $display("[TB] FAIL rnd_count@%0d: got %0d want %0d", c, count, mQ.size()); else nPass++;
            nChecks++; if (data !== mData) $display("[TB] FAIL rnd_data@%0d: got %h want %h", c, data, mData); else nPass++;
            nChecks++; if (overflow !== mOvf) $display("[TB] FAIL rnd_overflow@%0d: got %b want %b", c, overflow, mOvf); else nPass++;
            nChecks++; if (partial !== (mBuf.size() != 0)) $display("[TB] FAIL rnd_partial@%0d: got %b want %b", c, partial, mBuf.size() != 0); else nPass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resync();
        test_fill_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
